// File: rtl/uart_config_bank_if.sv
// rtl/uart_config_bank_if.sv - register-side config/readback bus for uart_config_bank
// Purpose: groups the write, error, and readback signals between the register file and the config bank.
// Ports (signals): cfg_wr/cfg_ch/cfg_wdata write request, cfg_err reject pulse,
//   cfg_rd/cfg_rd_ch/cfg_rd_shadow readback request, cfg_rdata/cfg_rd_status/cfg_rd_valid readback result.
interface uart_config_bank_if #(
    parameter int NUM_CH = 4
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic          cfg_wr;
    logic [CW-1:0] cfg_ch;
    logic [31:0]   cfg_wdata;
    logic          cfg_err;
    logic          cfg_rd;
    logic [CW-1:0] cfg_rd_ch;
    logic          cfg_rd_shadow;
    logic [31:0]   cfg_rdata;
    logic [2:0]    cfg_rd_status;
    logic          cfg_rd_valid;

    modport master (
        output cfg_wr, cfg_ch, cfg_wdata, cfg_rd, cfg_rd_ch, cfg_rd_shadow,
        input  cfg_err, cfg_rdata, cfg_rd_status, cfg_rd_valid
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_wdata, cfg_rd, cfg_rd_ch, cfg_rd_shadow,
        output cfg_err, cfg_rdata, cfg_rd_status, cfg_rd_valid
    );
endinterface

// File: rtl/uart_config_bank.sv
// rtl/uart_config_bank.sv - per-channel shadow/active UART configuration bank
// Purpose: validates config writes, stages them in a per-channel shadow word and commits to the active
//   word when the channel is idle or after APPLY_TIMEOUT busy cycles (forced apply).
// Ports: clk, reset (async, active-low); cfg (slave side of uart_config_bank_if);
//   ch_idle per-channel idle input; cfg_applied commit pulses; decoded active fields per channel
//   (baud_divisor, data_bits, parity_mode, two_stop_bits, tx_enable, rx_enable, fifo_enable, fifo_size).
module uart_config_bank #(
    parameter int NUM_CH        = 4,
    parameter int CLOCK_FREQ    = 100_000_000,
    parameter int DEFAULT_BAUD  = 9600,
    parameter int MIN_DIV       = 15,
    parameter int MAX_FIFO_CODE = 3,
    parameter int APPLY_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_config_bank_if.slave      cfg,
    input  logic [NUM_CH-1:0]      ch_idle,
    output logic [NUM_CH-1:0]      cfg_applied,
    output logic [16*NUM_CH-1:0]   baud_divisor,
    output logic [3*NUM_CH-1:0]    data_bits,
    output logic [2*NUM_CH-1:0]    parity_mode,
    output logic [NUM_CH-1:0]      two_stop_bits,
    output logic [NUM_CH-1:0]      tx_enable,
    output logic [NUM_CH-1:0]      rx_enable,
    output logic [NUM_CH-1:0]      fifo_enable,
    output logic [3*NUM_CH-1:0]    fifo_size
);
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNTW = (APPLY_TIMEOUT > 1) ? $clog2(APPLY_TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(APPLY_TIMEOUT - 1);
    localparam logic [15:0] DEF_DIV  = 16'(CLOCK_FREQ / DEFAULT_BAUD - 1);
    // 8N1, tx/rx/fifo enabled, fifo_size 0
    localparam logic [31:0] DEF_WORD = {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3'd3, DEF_DIV};

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} ch_state_t;

    ch_state_t         state_q  [NUM_CH];
    ch_state_t         state_d  [NUM_CH];
    logic [31:0]       shadow_q [NUM_CH];
    logic [31:0]       shadow_d [NUM_CH];
    logic [31:0]       active_q [NUM_CH];
    logic [31:0]       active_d [NUM_CH];
    logic [CNTW-1:0]   cnt_q    [NUM_CH];
    logic [CNTW-1:0]   cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] err_q, err_d, forced_q, forced_d, applied_q, applied_d;
    logic              cfg_err_q, cfg_err_d, rd_valid_q, rd_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [2:0]        status_q, status_d;
    logic              word_ok, wr_hit, timeout_hit;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        forced_d    = forced_q;
        applied_d   = '0;
        cfg_err_d   = 1'b0;
        rd_valid_d  = cfg.cfg_rd;
        rdata_d     = rdata_q;
        status_d    = status_q;
        wr_hit      = 1'b0;
        timeout_hit = 1'b0;

        word_ok = (cfg.cfg_wdata[15:0] >= 16'(MIN_DIV)) &&
                  !cfg.cfg_wdata[18] &&
                  (cfg.cfg_wdata[20:19] != 2'd3) &&
                  (cfg.cfg_wdata[27:25] <= 3'(MAX_FIFO_CODE)) &&
                  (cfg.cfg_wdata[31:28] == 4'd0);

        // Readback sees pre-edge state; its sticky clear is applied first so
        // that an event landing on the same edge is not lost.
        if (cfg.cfg_rd) begin
            rdata_d  = '0;
            status_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg.cfg_rd_ch == CW'(i)) begin
                    rdata_d     = cfg.cfg_rd_shadow ? shadow_q[i] : active_q[i];
                    status_d    = {state_q[i] == ST_WAIT, err_q[i], forced_q[i]};
                    err_d[i]    = 1'b0;
                    forced_d[i] = 1'b0;
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q[i] == ST_WAIT) begin
                timeout_hit = (APPLY_TIMEOUT != 0) && (cnt_q[i] == CNT_LAST);
                if (ch_idle[i] || timeout_hit) begin
                    active_d[i]  = shadow_q[i];
                    state_d[i]   = ST_IDLE;
                    cnt_d[i]     = '0;
                    applied_d[i] = 1'b1;
                    if (!ch_idle[i]) begin
                        forced_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // A write on the commit edge overrides the IDLE return: the old shadow
        // was committed above and the new word starts a fresh wait.
        if (cfg.cfg_wr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg.cfg_ch == CW'(i)) begin
                    wr_hit = 1'b1;
                    if (word_ok) begin
                        shadow_d[i] = cfg.cfg_wdata;
                        state_d[i]  = ST_WAIT;
                        cnt_d[i]    = '0;
                    end else begin
                        err_d[i] = 1'b1;
                    end
                end
            end
            cfg_err_d = !(word_ok && wr_hit);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                shadow_q[i] <= DEF_WORD;
                active_q[i] <= DEF_WORD;
                cnt_q[i]    <= '0;
            end
            err_q      <= '0;
            forced_q   <= '0;
            applied_q  <= '0;
            cfg_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            forced_q   <= forced_d;
            applied_q  <= applied_d;
            cfg_err_q  <= cfg_err_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
        end
    end

    assign cfg.cfg_err       = cfg_err_q;
    assign cfg.cfg_rdata     = rdata_q;
    assign cfg.cfg_rd_status = status_q;
    assign cfg.cfg_rd_valid  = rd_valid_q;
    assign cfg_applied       = applied_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fields
        assign baud_divisor[16*g +: 16] = active_q[g][15:0];
        assign data_bits[3*g +: 3]      = active_q[g][18:16];
        assign parity_mode[2*g +: 2]    = active_q[g][20:19];
        assign two_stop_bits[g]         = active_q[g][21];
        assign tx_enable[g]             = active_q[g][22];
        assign rx_enable[g]             = active_q[g][23];
        assign fifo_enable[g]           = active_q[g][24];
        assign fifo_size[3*g +: 3]      = active_q[g][27:25];
    end
endmodule
